// File: rtl/fp_div_seq.sv
// Sequential IEEE-754-style floating-point divider.
// Restoring radix-2 mantissa division (one quotient bit per cycle), then a
// single normalise/round cycle with round-to-nearest-even. Special operands
// (NaN, inf, zero, subnormal-as-zero) bypass the iterative datapath.
module fp_div_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] opd1,
  input  logic [W-1:0] opd2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         exp_overflow,
  output logic         nan,
  output logic         zero
);

  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned SE_W  = EXP_W + 2;
  localparam int unsigned MF_W  = MAN_W + 1;
  localparam int unsigned REM_W = MAN_W + 2;
  localparam int unsigned Q_W   = MAN_W + 3;
  localparam int unsigned CNT_W = $clog2(MAN_W + 4);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W + 2);
  localparam logic [SE_W-1:0]  EXP_MAX  = SE_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             nan_q, nan_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic [SE_W-1:0]  exp_q, exp_d;
  logic [MF_W-1:0]  div_q, div_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operand field decode
  logic             s1_c, s2_c;
  logic [EXP_W-1:0] e1_c, e2_c;
  logic [MAN_W-1:0] m1_c, m2_c;
  logic             a_nan_c, a_inf_c, a_zero_c;
  logic             b_nan_c, b_inf_c, b_zero_c;

  assign s1_c = opd1[W-1];
  assign s2_c = opd2[W-1];
  assign e1_c = opd1[W-2 -: EXP_W];
  assign e2_c = opd2[W-2 -: EXP_W];
  assign m1_c = opd1[MAN_W-1:0];
  assign m2_c = opd2[MAN_W-1:0];

  // Subnormals (exp == 0) count as zero regardless of mantissa
  assign a_nan_c  = (e1_c == '1) && (m1_c != '0);
  assign a_inf_c  = (e1_c == '1) && (m1_c == '0);
  assign a_zero_c = (e1_c == '0);
  assign b_nan_c  = (e2_c == '1) && (m2_c != '0);
  assign b_inf_c  = (e2_c == '1) && (m2_c == '0);
  assign b_zero_c = (e2_c == '0);

  // Special-operand classification and the result it produces
  logic         spec_c;
  logic [W-1:0] spec_res_c;
  logic         spec_ovf_c, spec_nan_c, spec_zero_c;
  logic         sgn_c;

  assign sgn_c = s1_c ^ s2_c;

  always_comb begin
    spec_c      = 1'b1;
    spec_res_c  = '0;
    spec_ovf_c  = 1'b0;
    spec_nan_c  = 1'b0;
    spec_zero_c = 1'b0;
    if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
      spec_res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_nan_c = 1'b1;
    end else if (a_inf_c) begin
      spec_res_c = {sgn_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero_c) begin
      spec_res_c = {sgn_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_ovf_c = 1'b1;
    end else if (a_zero_c || b_inf_c) begin
      spec_res_c  = {sgn_c, {(W-1){1'b0}}};
      spec_zero_c = 1'b1;
    end else begin
      spec_c = 1'b0;
    end
  end

  // One restoring-division step on the current partial remainder
  logic             rem_ge_c;
  logic [REM_W-1:0] rem_step_c, rem_next_c;

  always_comb begin
    rem_ge_c   = (rem_q >= REM_W'(div_q));
    rem_step_c = rem_ge_c ? (rem_q - REM_W'(div_q)) : rem_q;
    rem_next_c = REM_W'(rem_step_c << 1);
  end

  // Normalise, round to nearest even, and classify the finite result
  logic             guard_c, sticky_c, rnd_c;
  logic [MAN_W-1:0] mant_c;
  logic [MAN_W:0]   mant_r_c;
  logic [SE_W-1:0]  exp_n_c, exp_r_c;
  logic             norm_ovf_c, norm_zero_c;
  logic [W-1:0]     norm_res_c;

  always_comb begin
    if (quo_q[Q_W-1]) begin
      mant_c   = quo_q[Q_W-2:2];
      guard_c  = quo_q[1];
      sticky_c = quo_q[0] | (|rem_q);
      exp_n_c  = exp_q;
    end else begin
      mant_c   = quo_q[Q_W-3:1];
      guard_c  = quo_q[0];
      sticky_c = |rem_q;
      exp_n_c  = exp_q - SE_W'(1);
    end
    rnd_c       = guard_c & (sticky_c | mant_c[0]);
    mant_r_c    = {1'b0, mant_c} + (MAN_W+1)'(rnd_c);
    exp_r_c     = exp_n_c + SE_W'(mant_r_c[MAN_W]);
    norm_zero_c = exp_r_c[SE_W-1] || (exp_r_c == '0);
    norm_ovf_c  = !norm_zero_c && (exp_r_c >= EXP_MAX);
    if (norm_ovf_c) begin
      norm_res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (norm_zero_c) begin
      norm_res_c = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_res_c = {sign_q, exp_r_c[EXP_W-1:0], mant_r_c[MAN_W-1:0]};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = spec_c ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CNT_LAST) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next-value logic
  always_comb begin
    res_d  = res_q;
    ovf_d  = ovf_q;
    nan_d  = nan_q;
    zero_d = zero_q;
    sign_d = sign_q;
    exp_d  = exp_q;
    div_d  = div_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sgn_c;
          exp_d  = SE_W'(e1_c) - SE_W'(e2_c) + SE_W'(BIAS);
          rem_d  = REM_W'({1'b1, m1_c});
          div_d  = {1'b1, m2_c};
          quo_d  = '0;
          cnt_d  = '0;
          if (spec_c) begin
            res_d  = spec_res_c;
            ovf_d  = spec_ovf_c;
            nan_d  = spec_nan_c;
            zero_d = spec_zero_c;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_next_c;
        quo_d = {quo_q[Q_W-2:0], rem_ge_c};
        cnt_d = cnt_q + CNT_W'(1);
      end
      NORM: begin
        res_d  = norm_res_c;
        ovf_d  = norm_ovf_c;
        nan_d  = 1'b0;
        zero_d = norm_zero_c;
      end
      default: ;
    endcase
    out_valid_d = (state_q == DONE) && (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      nan_q       <= nan_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign res          = res_q;
  assign exp_overflow = ovf_q;
  assign nan          = nan_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq at default (single-precision) parameters.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opd1;
  logic [31:0] opd2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        exp_overflow;
  logic        nan;
  logic        zero;

  int errors = 0;
  int checks = 0;

  fp_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opd1         (opd1),
    .opd2         (opd2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res          (res),
    .exp_overflow (exp_overflow),
    .nan          (nan),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, hold the result for 'hold' cycles, then take it.
  // flags are {exp_overflow, nan, zero}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opd1 = a;
    opd2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    opd1 = ~a;
    opd2 = 32'h3F800000;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".res"}, res, exp_res);
    check({tag, ".flags"}, 32'({exp_overflow, nan, zero}), 32'(exp_flags));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {out_valid, in_ready, res[29:0]}, {1'b1, 1'b0, exp_res[29:0]});
      check({tag, ".hold_msb"}, 32'(res[31:30]), 32'(exp_res[31:30]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opd1 = '0;
    opd2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.res", res, 32'h0);
    check("rst.flags", 32'({exp_overflow, nan, zero}), 32'd0);

    // Finite operands through the iterative path
    run_op("6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28, 0);
    run_op("1div3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 28, 0);
    run_op("1div1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 28, 0);
    run_op("2div3",   32'h40000000, 32'h40400000, 32'h3F2AAAAB, 3'b000, 28, 0);
    run_op("m6div2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 28, 0);
    run_op("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 28, 0);
    run_op("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 3'b001, 28, 0);

    // Special operands bypass division
    run_op("0div0",   32'h00000000, 32'h00000000, 32'h7FC00000, 3'b010, 1, 0);
    run_op("1div0",   32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 1, 0);
    run_op("m1div0",  32'hBF800000, 32'h00000000, 32'hFF800000, 3'b100, 1, 0);
    run_op("infdiv2", 32'h7F800000, 32'h40000000, 32'h7F800000, 3'b000, 1, 0);
    run_op("infinf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b010, 1, 0);
    run_op("nanop",   32'h3F800000, 32'hFFC00001, 32'h7FC00000, 3'b010, 1, 0);
    run_op("m2dinf",  32'hC0000000, 32'h7F800000, 32'h80000000, 3'b001, 1, 0);
    run_op("subn",    32'h00000001, 32'h3F800000, 32'h00000000, 3'b001, 1, 0);

    // Backpressure for 10 cycles, then an immediate second operation
    run_op("bp",      32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28, 10);
    run_op("bp2",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 28, 0);

    // Reset pulse during DIVIDE abandons the operation
    @(negedge clk);
    in_valid = 1'b1;
    opd1 = 32'h40C00000;
    opd2 = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.state", 32'({out_valid, in_ready}), 32'b01);
    check("rstmid.res", res, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    check("rstmid.no_result", 32'(n), 32'd0);
    run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width.
- W = 1+EXP_W+MAN_W (derived, not overridable).
- BIAS = 2^(EXP_W-1)-1 (derived).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- opd1  in  W  dividend, IEEE-754-style {sign, exp, man}.
- opd2  in  W  divisor, same format.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- res  out  W  quotient.
- exp_overflow  out  1  result is inf from finite operands.
- nan  out  1  result is NaN.
- zero  out  1  result is zero.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE.
REQ-005 Accept when in_valid&&in_ready: opd1/opd2 registered; later input changes ignored until the next accept.
REQ-006 Special operands bypass DIVIDE: IDLE->DONE, out_valid high 1 cycle after accept.
REQ-007 Finite nonzero operands: IDLE->DIVIDE->NORM->DONE; out_valid high exactly MAN_W+5 cycles after accept (28 at defaults).
REQ-008 Subnormal inputs (exp=0, man!=0) treated as ±0; subnormal results flushed to ±0.
REQ-009 Sign = sign1 XOR sign2 for all non-NaN results.
REQ-010 Exponent: e1-e2+BIAS, computed signed on EXP_W+2 bits.
REQ-011 DIVIDE: radix-2 restoring division of {1,man1} by {1,man2}, one quotient bit per cycle, MAN_W+3 cycles; iteration counter is $clog2(MAN_W+4) bits.
REQ-012 Sticky = OR of final remainder bits.
REQ-013 NORM (1 cycle): if quotient MSB=0, shift left 1 and decrement exponent.
- Then round to nearest, ties to even, using guard and sticky.
- Mantissa carry-out renormalises and increments exponent.
REQ-014 Post-round exponent >= 2^EXP_W-1: res=±inf, exp_overflow=1.
REQ-015 Post-round exponent <= 0: res=±0, zero=1.
REQ-016 Special-case table:
- any NaN operand, 0/0, inf/inf: res = {0, all-ones exp, man MSB=1, rest 0}, nan=1.
- finite nonzero / 0: ±inf, exp_overflow=1.
- inf / finite: ±inf, flags 0.
- 0 / nonzero non-NaN, finite / inf: ±0, zero=1.
REQ-017 Flags are mutually exclusive; all 0 for normal results.
REQ-018 DONE: res and flags held stable while out_valid && !out_ready.
REQ-019 Transfer on out_valid&&out_ready: DONE->IDLE, out_valid=0 and in_ready=1 next cycle; no accept in the transfer cycle.
REQ-020 res and flags are registered outputs; they hold the last result in IDLE and are valid only while out_valid=1.

Reset
REQ-021 rst=1 at a clock edge: state IDLE, in_ready=1, out_valid=0, res=0, all flags 0, counter 0; overrides any handshake in the same cycle.
REQ-022 rst asserted in DIVIDE, NORM or DONE abandons the operation; no result is ever presented for it.
REQ-023 First operation after reset release behaves exactly as from power-up.

Verification
REQ-024 0x40C00000 / 0x40000000 -> res 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
REQ-025 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (RNE round-up).
- 0x3F800000 / 0x3F800000 -> 0x3F800000.
REQ-026 0x00000000 / 0x00000000 -> 0x7FC00000, nan=1, out_valid 1 cycle after accept.
- 0x3F800000 / 0x00000000 -> 0x7F800000, exp_overflow=1.
REQ-027 0x7F000000 / 0x00800000 -> 0x7F800000, exp_overflow=1.
- 0x00800000 / 0x7F000000 -> 0x00000000, zero=1.
REQ-028 Backpressure: out_ready=0 for 10 cycles in DONE -> res stable, in_ready=0 throughout.
- Then handshake -> in_ready=1 the following cycle.
- A second operation issued then is correct.
REQ-029 rst pulsed for 1 cycle at DIVIDE cycle 5 -> next cycle out_valid=0, in_ready=1; a subsequent 6.0/2.0 gives 0x40400000 after 28 cycles.
